// File: rtl/dds_seq_pkg.sv
// Shared definitions for the DDS phase sequencer.
// Holds the default widths and the sequencer state encoding.
package dds_seq_pkg;

  localparam int unsigned DefPhaseWidth = 48;
  localparam int unsigned DefCountWidth = 32;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StArmed    = 2'd1,
    StRun      = 2'd2,
    StStopping = 2'd3
  } dds_state_e;

endpackage

// File: rtl/dds_phase_acc.sv
// DDS phase accumulator register.
// Ports:
//   clk_i, reset_i  clock and synchronous active-high reset
//   en_i            advance the accumulator by freq_i this cycle
//   clear_i         force the accumulator to zero (channel start)
//   load_zero_i     force the accumulator to zero (external sync)
//   freq_i          phase increment
//   acc_o           current accumulator value
//   carry_o         carry-out of the increment that commits this cycle
//   carry_q_o       high when acc_o was produced by a carry
module dds_phase_acc
  import dds_seq_pkg::*;
#(
  parameter int unsigned PHASE_WIDTH = DefPhaseWidth
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   en_i,
  input  logic                   clear_i,
  input  logic                   load_zero_i,
  input  logic [PHASE_WIDTH-1:0] freq_i,
  output logic [PHASE_WIDTH-1:0] acc_o,
  output logic                   carry_o,
  output logic                   carry_q_o
);

  logic [PHASE_WIDTH:0]   sum;
  logic [PHASE_WIDTH-1:0] acc_q;
  logic                   carry_q;

  assign sum = {1'b0, acc_q} + {1'b0, freq_i};

  // A carry that is overridden by a zero load never happened as far as the
  // rest of the channel is concerned.
  assign carry_o = en_i && !clear_i && !load_zero_i && sum[PHASE_WIDTH];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      acc_q   <= '0;
      carry_q <= 1'b0;
    end else if (clear_i || load_zero_i) begin
      acc_q   <= '0;
      carry_q <= 1'b0;
    end else if (en_i) begin
      acc_q   <= sum[PHASE_WIDTH-1:0];
      carry_q <= sum[PHASE_WIDTH];
    end else begin
      carry_q <= 1'b0;
    end
  end

  assign acc_o     = acc_q;
  assign carry_q_o = carry_q;

endmodule

// File: rtl/dds_phase_sequencer.sv
// DDS phase sequencer for one channel: start/stop control, external phase
// sync, period-boundary config updates and a saturating period counter.
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   cfg_freq/cfg_phase   new phase increment / phase offset
//   cfg_valid/cfg_ready  config handshake into a single shadow register
//   start, stop          single-cycle control pulses (stop wins)
//   trig_sync            external sync: zeroes the accumulator while running
//   m_axis_*_phase       phase sample stream, no backpressure
//   wrap                 pulse aligned with the first sample after a carry
//   running              channel is in RUN or STOPPING
//   period_count         wraps since the last start, saturating
// Build option: define DDS_SEQ_SYNC_START_EN to make start arm the channel
// and let the next trig_sync begin the run.
module dds_phase_sequencer
  import dds_seq_pkg::*;
#(
  parameter int unsigned PHASE_WIDTH = DefPhaseWidth,
  parameter int unsigned COUNT_WIDTH = DefCountWidth
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PHASE_WIDTH-1:0] cfg_freq,
  input  logic [PHASE_WIDTH-1:0] cfg_phase,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   trig_sync,
  output logic [PHASE_WIDTH-1:0] m_axis_tdata_phase,
  output logic                   m_axis_tvalid_phase,
  output logic                   wrap,
  output logic                   running,
  output logic [COUNT_WIDTH-1:0] period_count
);

`ifdef DDS_SEQ_SYNC_START_EN
  localparam dds_state_e StartTarget = StArmed;
`else
  localparam dds_state_e StartTarget = StRun;
`endif

  dds_state_e             state_q;
  logic                   pending_q;
  logic [PHASE_WIDTH-1:0] shadow_freq_q;
  logic [PHASE_WIDTH-1:0] shadow_phase_q;
  logic [PHASE_WIDTH-1:0] freq_act_q;
  logic [PHASE_WIDTH-1:0] phase_off_q;
  logic [PHASE_WIDTH-1:0] tdata_q;
  logic                   tvalid_q;
  logic                   wrap_q;
  logic [COUNT_WIDTH-1:0] count_q;

  logic [PHASE_WIDTH-1:0] acc;
  logic                   acc_carry;
  logic                   acc_carry_q;

  logic active;
  logic start_ok;
  logic enter_run;
  logic resync;
  logic cfg_accept;
  logic cfg_apply;
  logic tvalid_d;

  assign active   = (state_q == StRun) || (state_q == StStopping);
  assign start_ok = (state_q == StIdle) && start && !stop;

`ifdef DDS_SEQ_SYNC_START_EN
  assign enter_run = (state_q == StArmed) && trig_sync && !stop;
`else
  assign enter_run = start_ok;
`endif

  assign resync     = active && trig_sync;
  assign cfg_accept = cfg_valid && !pending_q;
  // While stopped a pending config lands at once; while running it waits for
  // a committed carry so the step never changes mid-period.
  assign cfg_apply  = pending_q && (!active || acc_carry);

  // The sample produced from a carried accumulator is the wrapped sample; in
  // STOPPING it is suppressed, as is anything after a second stop.
  assign tvalid_d = (state_q == StRun) ||
                    ((state_q == StStopping) && !acc_carry_q && !stop);

  dds_phase_acc #(
    .PHASE_WIDTH (PHASE_WIDTH)
  ) u_acc (
    .clk_i       (clk),
    .reset_i     (reset),
    .en_i        (active),
    .clear_i     (enter_run),
    .load_zero_i (resync),
    .freq_i      (freq_act_q),
    .acc_o       (acc),
    .carry_o     (acc_carry),
    .carry_q_o   (acc_carry_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      pending_q      <= 1'b0;
      shadow_freq_q  <= '0;
      shadow_phase_q <= '0;
      freq_act_q     <= '0;
      phase_off_q    <= '0;
      tdata_q        <= '0;
      tvalid_q       <= 1'b0;
      wrap_q         <= 1'b0;
      count_q        <= '0;
    end else begin
      // Config shadow and active registers.
      if (cfg_accept) begin
        shadow_freq_q  <= cfg_freq;
        shadow_phase_q <= cfg_phase;
        pending_q      <= 1'b1;
      end else if (cfg_apply) begin
        pending_q      <= 1'b0;
      end
      if (cfg_apply) begin
        freq_act_q  <= shadow_freq_q;
        phase_off_q <= shadow_phase_q;
      end

      // Output stage: one cycle behind the accumulator.
      tvalid_q <= tvalid_d;
      wrap_q   <= active && acc_carry_q;
      if (active) begin
        tdata_q <= acc + phase_off_q;
      end

      if (enter_run) begin
        count_q <= '0;
      end else if (active && acc_carry_q && (count_q != '1)) begin
        count_q <= count_q + 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (start_ok) state_q <= StartTarget;
        end
        StArmed: begin
          if (stop)           state_q <= StIdle;
          else if (trig_sync) state_q <= StRun;
        end
        StRun: begin
          if (stop) state_q <= StStopping;
        end
        StStopping: begin
          if (stop || acc_carry_q) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cfg_ready           = !pending_q;
  assign m_axis_tdata_phase  = tdata_q;
  assign m_axis_tvalid_phase = tvalid_q;
  assign wrap                = wrap_q;
  assign running             = active;
  assign period_count        = count_q;

endmodule
